// File: rtl/instr_decode_if.sv
// Fetch-side handshake plus decoded bundle for the MIPS-I decode stage.
// The master modport is the fetch/downstream side and the slave modport is the decode stage.
interface instr_decode_if #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [5:0]      out_opcode;
    logic [4:0]      out_rs;
    logic [4:0]      out_rt;
    logic [4:0]      out_rd;
    logic [4:0]      out_shamt;
    logic [5:0]      out_funct;
    logic [1:0]      out_fmt;
    logic [XLEN-1:0] out_imm_ext;
    logic [PC_W-1:0] out_br_target;
    logic [PC_W-1:0] out_j_target;
    logic [4:0]      out_wr_reg;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_rs, out_rt, out_rd,
               out_shamt, out_funct, out_fmt, out_imm_ext, out_br_target,
               out_j_target, out_wr_reg, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_rs, out_rt, out_rd,
               out_shamt, out_funct, out_fmt, out_imm_ext, out_br_target,
               out_j_target, out_wr_reg, out_illegal
    );
endinterface

// File: rtl/instr_decode_stage.sv
// Registered MIPS-I decode stage: field split, format class, immediate extension,
// branch/jump targets, destination register, illegal-opcode flag and a saturating decode counter.
module instr_decode_stage #(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    instr_decode_if.slave    dec_bus,
    output logic [CNT_W-1:0] o_stat_decoded
);
    logic [31:0]     w_instr;
    logic [5:0]      w_op;
    logic [15:0]     w_imm;
    logic            w_in_ready;
    logic            w_accept;
    logic            w_legal;
    logic [1:0]      w_fmt;
    logic [XLEN-1:0] w_imm_ext;
    logic [PC_W-1:0] w_pc4;
    logic [PC_W-1:0] w_br_target;
    logic [PC_W-1:0] w_j_target;
    logic [4:0]      w_wr_reg;

    logic             r_valid;
    logic [PC_W-1:0]  r_pc;
    logic [31:0]      r_instr;
    logic [1:0]       r_fmt;
    logic [XLEN-1:0]  r_imm_ext;
    logic [PC_W-1:0]  r_br_target;
    logic [PC_W-1:0]  r_j_target;
    logic [4:0]       r_wr_reg;
    logic             r_illegal;
    logic [CNT_W-1:0] r_cnt;

    assign w_instr    = dec_bus.in_instr;
    assign w_op       = w_instr[31:26];
    assign w_imm      = w_instr[15:0];
    assign w_in_ready = !i_rst && (!r_valid || dec_bus.out_ready);
    assign w_accept   = dec_bus.in_valid && w_in_ready && !dec_bus.flush;

    // Targets wrap modulo 2^PC_W; the jump keeps the top four bits of pc+4.
    assign w_pc4       = dec_bus.in_pc + PC_W'(4);
    assign w_br_target = w_pc4 + PC_W'($signed({w_imm, 2'b00}));
    assign w_j_target  = (w_pc4 & ~PC_W'(32'h0FFF_FFFF)) | PC_W'({w_instr[25:0], 2'b00});

    always_comb begin
        w_legal = 1'b0;
        case (w_op)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
            6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B: w_legal = 1'b1;
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_fmt = 2'b01;
        if (w_op == 6'h00) begin
            w_fmt = 2'b00;
        end else if (w_op == 6'h02 || w_op == 6'h03) begin
            w_fmt = 2'b10;
        end
    end

    always_comb begin
        w_imm_ext = XLEN'($signed(w_imm));
        case (w_op)
            6'h0C, 6'h0D, 6'h0E: w_imm_ext = XLEN'(w_imm);
            6'h0F:               w_imm_ext = XLEN'({w_imm, 16'h0000});
            default:             w_imm_ext = XLEN'($signed(w_imm));
        endcase
    end

    // Illegal opcodes never write a register even though they travel downstream.
    always_comb begin
        w_wr_reg = w_instr[20:16];
        if (!w_legal) begin
            w_wr_reg = 5'd0;
        end else begin
            case (w_op)
                6'h00:                      w_wr_reg = w_instr[15:11];
                6'h03:                      w_wr_reg = 5'd31;
                6'h02, 6'h04, 6'h05, 6'h2B: w_wr_reg = 5'd0;
                default:                    w_wr_reg = w_instr[20:16];
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_instr     <= '0;
            r_fmt       <= '0;
            r_imm_ext   <= '0;
            r_br_target <= '0;
            r_j_target  <= '0;
            r_wr_reg    <= '0;
            r_illegal   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            if (dec_bus.flush) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid     <= 1'b1;
                r_pc        <= dec_bus.in_pc;
                r_instr     <= w_instr;
                r_fmt       <= w_fmt;
                r_imm_ext   <= w_imm_ext;
                r_br_target <= w_br_target;
                r_j_target  <= w_j_target;
                r_wr_reg    <= w_wr_reg;
                r_illegal   <= !w_legal;
            end else if (r_valid && dec_bus.out_ready) begin
                r_valid <= 1'b0;
            end
            if (w_accept && r_cnt != '1) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign dec_bus.in_ready      = w_in_ready;
    assign dec_bus.out_valid     = r_valid;
    assign dec_bus.out_pc        = r_pc;
    assign dec_bus.out_opcode    = r_instr[31:26];
    assign dec_bus.out_rs        = r_instr[25:21];
    assign dec_bus.out_rt        = r_instr[20:16];
    assign dec_bus.out_rd        = r_instr[15:11];
    assign dec_bus.out_shamt     = r_instr[10:6];
    assign dec_bus.out_funct     = r_instr[5:0];
    assign dec_bus.out_fmt       = r_fmt;
    assign dec_bus.out_imm_ext   = r_imm_ext;
    assign dec_bus.out_br_target = r_br_target;
    assign dec_bus.out_j_target  = r_j_target;
    assign dec_bus.out_wr_reg    = r_wr_reg;
    assign dec_bus.out_illegal   = r_illegal;
    assign o_stat_decoded        = r_cnt;
endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: directed scenarios then random traffic, checked every cycle
// against an arithmetic reference of the decode rules and the handshake.
module tb_instr_decode_stage;
    typedef struct {
        logic [1:0]  fmt;
        logic [31:0] imm;
        logic [31:0] br;
        logic [31:0] jt;
        logic [4:0]  wr;
        logic        ill;
    } ref_t;

    logic        clk;
    logic        rst;
    logic [15:0] stat;
    logic [1:0]  stat2;
    int          n_chk;
    int          n_pass;

    bit          m_valid;
    bit          m_zero;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    int          m_cnt;

    instr_decode_if #(.XLEN(32), .PC_W(32)) dec_if ();
    instr_decode_if #(.XLEN(32), .PC_W(32)) dec_if2 ();

    instr_decode_stage #(.XLEN(32), .PC_W(32), .CNT_W(16)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .dec_bus        (dec_if.slave),
        .o_stat_decoded (stat)
    );

    instr_decode_stage #(.XLEN(32), .PC_W(32), .CNT_W(2)) dut2 (
        .i_clk          (clk),
        .i_rst          (rst),
        .dec_bus        (dec_if2.slave),
        .o_stat_decoded (stat2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic ref_t ref_dec(input logic [31:0] ins, input logic [31:0] pc);
        ref_t r;
        int op;
        int imm16;
        int simm;
        logic [31:0] pc4;
        op    = int'(ins[31:26]);
        imm16 = int'(ins[15:0]);
        simm  = (imm16 >= 32768) ? imm16 - 65536 : imm16;
        pc4   = pc + 32'd4;
        r.fmt = (op == 0) ? 2'd0 : ((op == 2 || op == 3) ? 2'd2 : 2'd1);
        r.ill = !(op inside {0, 2, 3, 4, 5, 8, 9, 10, 11, 12, 13, 14, 15, 35, 43});
        if (op inside {12, 13, 14}) r.imm = imm16;
        else if (op == 15)          r.imm = imm16 * 65536;
        else                        r.imm = simm;
        r.br = pc4 + simm * 4;
        r.jt = (pc4 & 32'hF000_0000) + int'(ins[25:0]) * 4;
        if (r.ill)                        r.wr = 5'd0;
        else if (op == 0)                 r.wr = ins[15:11];
        else if (op == 3)                 r.wr = 5'd31;
        else if (op inside {2, 4, 5, 43}) r.wr = 5'd0;
        else                              r.wr = ins[20:16];
        return r;
    endfunction

    task automatic check_outs();
        ref_t r;
        chk("out_valid", dec_if.out_valid, m_valid);
        chk("stat_decoded", stat, m_cnt);
        if (m_valid) begin
            r = ref_dec(m_instr, m_pc);
            chk("out_pc", dec_if.out_pc, m_pc);
            chk("out_opcode", dec_if.out_opcode, m_instr[31:26]);
            chk("out_rs", dec_if.out_rs, m_instr[25:21]);
            chk("out_rt", dec_if.out_rt, m_instr[20:16]);
            chk("out_rd", dec_if.out_rd, m_instr[15:11]);
            chk("out_shamt", dec_if.out_shamt, m_instr[10:6]);
            chk("out_funct", dec_if.out_funct, m_instr[5:0]);
            chk("out_fmt", dec_if.out_fmt, r.fmt);
            chk("out_imm_ext", dec_if.out_imm_ext, r.imm);
            chk("out_br_target", dec_if.out_br_target, r.br);
            chk("out_j_target", dec_if.out_j_target, r.jt);
            chk("out_wr_reg", dec_if.out_wr_reg, r.wr);
            chk("out_illegal", dec_if.out_illegal, r.ill);
        end else if (m_zero) begin
            chk("rst_pc", dec_if.out_pc, 0);
            chk("rst_opcode", dec_if.out_opcode, 0);
            chk("rst_imm", dec_if.out_imm_ext, 0);
            chk("rst_br", dec_if.out_br_target, 0);
            chk("rst_jt", dec_if.out_j_target, 0);
            chk("rst_wr", dec_if.out_wr_reg, 0);
        end
    endtask

    // One clock cycle: drive at the falling edge, update the model at the rising edge,
    // compare at the next falling edge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic fl, input logic ordy);
        bit exp_ready;
        bit acc;
        dec_if.in_valid  = v;
        dec_if.in_instr  = ins;
        dec_if.in_pc     = pc;
        dec_if.flush     = fl;
        dec_if.out_ready = ordy;
        #1;
        exp_ready = !rst && (!m_valid || ordy);
        chk("in_ready", dec_if.in_ready, exp_ready);
        acc = v && exp_ready && !fl;
        @(posedge clk);
        if (rst) begin
            m_valid = 0;
            m_zero  = 1;
            m_cnt   = 0;
        end else begin
            if (fl) begin
                m_valid = 0;
            end else if (acc) begin
                m_valid = 1;
                m_zero  = 0;
                m_instr = ins;
                m_pc    = pc;
            end else if (m_valid && ordy) begin
                m_valid = 0;
            end
            if (acc && m_cnt < 65535) m_cnt++;
        end
        @(negedge clk);
        check_outs();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] legal [15] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                                   6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 3) != 0) w[31:26] = legal[$urandom_range(0, 14)];
        return w;
    endfunction

    function automatic logic [31:0] rand_pc();
        case ($urandom_range(0, 7))
            0:       return 32'hFFFF_FFFC;
            1:       return 32'h0FFF_FFFC;
            default: return $urandom & 32'hFFFF_FFFC;
        endcase
    endfunction

    initial begin
        int c0;
        n_chk   = 0;
        n_pass  = 0;
        m_valid = 0;
        m_zero  = 0;
        m_cnt   = 0;
        m_instr = '0;
        m_pc    = '0;
        rst     = 1'b1;
        dec_if.in_valid   = 1'b0;
        dec_if.in_instr   = '0;
        dec_if.in_pc      = '0;
        dec_if.flush      = 1'b0;
        dec_if.out_ready  = 1'b0;
        dec_if2.in_valid  = 1'b0;
        dec_if2.in_instr  = 32'h2021_0001;
        dec_if2.in_pc     = '0;
        dec_if2.flush     = 1'b0;
        dec_if2.out_ready = 1'b1;
        @(negedge clk);

        // reset holds for two cycles with fetch already offering work
        step(1, 32'h012A_4020, 32'h0, 0, 1);
        step(1, 32'h012A_4020, 32'h0, 0, 1);
        chk("rst_in_ready", dec_if.in_ready, 0);
        chk("rst_stat", stat, 0);
        chk("rst_stat2", stat2, 0);
        rst = 1'b0;

        // R-type add $8,$9,$10
        step(1, 32'h012A_4020, 32'h0040_0000, 0, 1);
        chk("add_fmt", dec_if.out_fmt, 2'b00);
        chk("add_rs", dec_if.out_rs, 9);
        chk("add_rt", dec_if.out_rt, 10);
        chk("add_rd", dec_if.out_rd, 8);
        chk("add_funct", dec_if.out_funct, 6'h20);
        chk("add_wr", dec_if.out_wr_reg, 8);

        step(1, 32'h1109_FFFF, 32'h0000_0100, 0, 1);
        chk("beq_br", dec_if.out_br_target, 32'h0000_0100);
        chk("beq_wr", dec_if.out_wr_reg, 0);
        step(1, 32'h0C10_0000, 32'h0040_0000, 0, 1);
        chk("jal_jt", dec_if.out_j_target, 32'h0040_0000);
        chk("jal_wr", dec_if.out_wr_reg, 31);

        step(1, 32'h3C01_1234, 32'h0, 0, 1);
        chk("lui_imm", dec_if.out_imm_ext, 32'h1234_0000);
        step(1, 32'h3421_FFFF, 32'h0, 0, 1);
        chk("ori_imm", dec_if.out_imm_ext, 32'h0000_FFFF);
        step(1, 32'h2021_FFFF, 32'h0, 0, 1);
        chk("addi_imm", dec_if.out_imm_ext, 32'hFFFF_FFFF);

        // backpressure: one held bundle, stable outputs, then flush
        step(1, 32'h8C22_0008, 32'h0000_2000, 0, 1);
        c0 = int'(stat);
        for (int i = 0; i < 3; i++) begin
            step(1, 32'hAC22_0004, 32'h0000_3000, 0, 0);
            chk("bp_pc", dec_if.out_pc, 32'h0000_2000);
            chk("bp_stat", stat, c0);
        end
        step(1, 32'hAC22_0004, 32'h0000_3000, 1, 0);
        chk("flush_valid", dec_if.out_valid, 0);
        chk("flush_stat", stat, c0);

        step(1, 32'hFC00_FFFF, 32'h0000_4000, 0, 1);
        chk("ill_flag", dec_if.out_illegal, 1);
        chk("ill_wr", dec_if.out_wr_reg, 0);

        // narrow counter saturates at 3
        dec_if2.in_valid = 1'b1;
        step(0, 32'h0, 32'h0, 0, 1);
        step(0, 32'h0, 32'h0, 0, 1);
        chk("cnt2_two", stat2, 2);
        step(0, 32'h0, 32'h0, 0, 1);
        step(0, 32'h0, 32'h0, 0, 1);
        step(0, 32'h0, 32'h0, 0, 1);
        chk("cnt2_sat", stat2, 3);
        dec_if2.in_valid = 1'b0;

        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            step($urandom_range(0, 3) != 0, rand_instr(), rand_pc(),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);
        end
        rst = 1'b0;
        step(0, 32'h0, 32'h0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
